// File: rtl/x7dn_resp_misr.sv
// Multiple-input signature register that compacts a run of x7dn response words
// into a 15-bit signature, with a start / stream / hand-off control FSM.
module x7dn_resp_misr #(
    parameter logic [14:0] POLY = 15'h6001,
    parameter logic [14:0] SEED = 15'h7FFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_samples,
    input  logic [14:0] y,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [14:0] sig,
    output logic        sig_valid,
    input  logic        sig_ready,
    output logic [15:0] sample_cnt,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for start; sig keeps the last signature
    // RUN   | accepting response words into the MISR
    // HOLD  | final signature presented until the consumer takes it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] num_q;
    logic [15:0] num_d;
    logic [14:0] sig_d;
    logic [15:0] cnt_d;
    logic [15:0] cnt_inc;
    logic        accept;

    always_comb begin
        state_d   = state_q;
        sig_d     = sig;
        cnt_d     = sample_cnt;
        num_d     = num_q;
        in_ready  = (state_q == RUN);
        sig_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        accept    = in_valid & in_ready;
        cnt_inc   = sample_cnt + 16'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = num_samples;
                    sig_d   = SEED;
                    cnt_d   = 16'd0;
                    state_d = (num_samples != 16'd0) ? RUN : HOLD;
                end
            end
            RUN: begin
                if (accept) begin
                    sig_d = {sig[13:0], 1'b0} ^ (sig[14] ? POLY : 15'h0) ^ y;
                    cnt_d = cnt_inc;
                    // RUN is only entered with a nonzero target, so the count never wraps
                    if (cnt_inc == num_q) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (sig_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sig        <= SEED;
            sample_cnt <= 16'd0;
            num_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            sig        <= sig_d;
            sample_cnt <= cnt_d;
            num_q      <= num_d;
        end
    end

endmodule

// File: tb/tb_x7dn_resp_misr.sv
// Directed self-checking bench for x7dn_resp_misr: handshake, stalls, zero-length
// runs, hold stability, mid-run reset and a long randomly stalled run.
module tb_x7dn_resp_misr;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic [14:0] y;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] sig;
    logic        sig_valid;
    logic        sig_ready;
    logic [15:0] sample_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    x7dn_resp_misr #(.POLY(15'h6001), .SEED(15'h7FFF)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .y(y),
        .in_valid(in_valid), .in_ready(in_ready), .sig(sig), .sig_valid(sig_valid),
        .sig_ready(sig_ready), .sample_cnt(sample_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] misr_step(input logic [14:0] s, input logic [14:0] d);
        logic [14:0] r;
        r = {s[13:0], 1'b0} ^ d;
        if (s[14]) r = r ^ 15'h6001;
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; sig_ready = 1'b1;
        num_samples = 16'd3; y = 15'h1111;
        tick;
        tick;
        checks++; if (sig !== 15'h7FFF) begin errors++; $display("FAIL reset_sig got %h exp 7fff", sig); end
        checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", sample_cnt); end
        checks++; if ({sig_valid, in_ready, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {sig_valid, in_ready, busy}); end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; sig_ready = 1'b0;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_single;
        start = 1'b1; num_samples = 16'd1;
        tick;
        start = 1'b0;
        checks++; if ({in_ready, busy, sig_valid} !== 3'b110) begin errors++; $display("FAIL single_run_flags got %b exp 110", {in_ready, busy, sig_valid}); end
        checks++; if (sig !== 15'h7FFF || sample_cnt !== 16'd0) begin errors++; $display("FAIL single_seed got %h/%0d exp 7fff/0", sig, sample_cnt); end
        in_valid = 1'b1; y = 15'h0000;
        tick;
        in_valid = 1'b0;
        checks++; if (sig !== 15'h1FFF) begin errors++; $display("FAIL single_sig got %h exp 1fff", sig); end
        checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", sample_cnt); end
        checks++; if ({sig_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL single_hold got %b exp 10", {sig_valid, in_ready}); end
        sig_ready = 1'b1;
        tick;
        sig_ready = 1'b0;
        checks++; if ({sig_valid, busy} !== 2'b00 || sig !== 15'h1FFF) begin errors++; $display("FAIL single_release got %b sig %h exp 00 sig 1fff", {sig_valid, busy}, sig); end
    endtask

    task automatic test_stall;
        start = 1'b1; num_samples = 16'd2;
        tick;
        start = 1'b0; num_samples = 16'd5;
        in_valid = 1'b1; y = 15'h0000;
        tick;
        in_valid = 1'b0; y = 15'h7ABC;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (sig !== 15'h1FFF || sample_cnt !== 16'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_%0d got sig %h cnt %0d rdy %b exp 1fff 1 1", i, sig, sample_cnt, in_ready); end
        end
        in_valid = 1'b1; y = 15'h0000;
        tick;
        in_valid = 1'b0; y = 15'h5555;
        checks++; if (sig !== 15'h3FFE || sample_cnt !== 16'd2) begin errors++; $display("FAIL stall_sig got %h/%0d exp 3ffe/2", sig, sample_cnt); end
        checks++; if ({in_ready, sig_valid} !== 2'b01) begin errors++; $display("FAIL stall_done got %b exp 01", {in_ready, sig_valid}); end
        tick;
        tick;
        checks++; if (sig !== 15'h3FFE || sig_valid !== 1'b1) begin errors++; $display("FAIL stall_held got %h/%b exp 3ffe/1", sig, sig_valid); end
        sig_ready = 1'b1;
        tick;
        sig_ready = 1'b0;
        checks++; if (busy !== 1'b0 || sig !== 15'h3FFE) begin errors++; $display("FAIL stall_release got busy %b sig %h exp 0 3ffe", busy, sig); end
    endtask

    task automatic test_zero;
        start = 1'b1; num_samples = 16'd0;
        tick;
        start = 1'b0;
        checks++; if (sig !== 15'h7FFF || sample_cnt !== 16'd0) begin errors++; $display("FAIL zero_sig got %h/%0d exp 7fff/0", sig, sample_cnt); end
        checks++; if ({sig_valid, in_ready, busy} !== 3'b101) begin errors++; $display("FAIL zero_flags got %b exp 101", {sig_valid, in_ready, busy}); end
        start = 1'b1; num_samples = 16'd4; sig_ready = 1'b1;
        tick;
        start = 1'b0; sig_ready = 1'b0;
        checks++; if ({busy, sig_valid} !== 2'b00) begin errors++; $display("FAIL zero_release got %b exp 00", {busy, sig_valid}); end
        tick;
        checks++; if (busy !== 1'b0 || sample_cnt !== 16'd0) begin errors++; $display("FAIL zero_no_latch got busy %b cnt %0d exp 0 0", busy, sample_cnt); end
    endtask

    task automatic test_hold_stable;
        start = 1'b1; num_samples = 16'd1;
        tick;
        start = 1'b0; in_valid = 1'b1; y = 15'h1234;
        tick;
        for (int i = 0; i < 10; i++) begin
            start = i[0]; in_valid = ~i[0]; y = 15'h0F0F; num_samples = 16'd9;
            tick;
            checks++; if (sig !== 15'h0DCB || sample_cnt !== 16'd1 || sig_valid !== 1'b1) begin errors++; $display("FAIL hold_%0d got sig %h cnt %0d v %b exp 0dcb 1 1", i, sig, sample_cnt, sig_valid); end
        end
        start = 1'b0; in_valid = 1'b0; sig_ready = 1'b1;
        tick;
        sig_ready = 1'b0;
        checks++; if ({busy, sig_valid} !== 2'b00) begin errors++; $display("FAIL hold_release got %b exp 00", {busy, sig_valid}); end
    endtask

    task automatic test_reset_midrun;
        start = 1'b1; num_samples = 16'd5;
        tick;
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            y = 15'(i * 37 + 5);
            tick;
        end
        checks++; if (sample_cnt !== 16'd3) begin errors++; $display("FAIL midrun_cnt got %0d exp 3", sample_cnt); end
        rst = 1'b1; sig_ready = 1'b1; start = 1'b1;
        tick;
        rst = 1'b0; sig_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0 || sig !== 15'h7FFF || sample_cnt !== 16'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL midrun_rst got busy %b sig %h cnt %0d rdy %b exp 0 7fff 0 0", busy, sig, sample_cnt, in_ready); end
        tick;
        tick;
        checks++; if (sig_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_no_valid got %b/%b exp 0/0", sig_valid, busy); end
        start = 1'b1; num_samples = 16'd1;
        tick;
        start = 1'b0; in_valid = 1'b1; y = 15'h0000;
        tick;
        in_valid = 1'b0;
        checks++; if (sig !== 15'h1FFF || sig_valid !== 1'b1) begin errors++; $display("FAIL midrun_rerun got %h/%b exp 1fff/1", sig, sig_valid); end
        sig_ready = 1'b1;
        tick;
        sig_ready = 1'b0;
    endtask

    task automatic test_random_run;
        logic [14:0] model;
        int          n;
        int          cycles;
        bit          rdy_bad;
        model = 15'h7FFF; n = 0; cycles = 0; rdy_bad = 1'b0;
        start = 1'b1; num_samples = 16'd1000;
        tick;
        start = 1'b0;
        while (n < 1000 && cycles < 5000) begin
            in_valid = ($urandom_range(0, 2) != 0);
            y = 15'($urandom);
            if (in_ready !== 1'b1) rdy_bad = 1'b1;
            if (in_valid) begin
                model = misr_step(model, y);
                n++;
            end
            tick;
            cycles++;
        end
        in_valid = 1'b0;
        checks++; if (n != 1000) begin errors++; $display("FAIL rand_timeout accepted %0d exp 1000", n); end
        checks++; if (rdy_bad) begin errors++; $display("FAIL rand_ready got in_ready low during run exp high"); end
        checks++; if (sig !== model) begin errors++; $display("FAIL rand_sig got %h exp %h", sig, model); end
        checks++; if (sample_cnt !== 16'd1000 || sig_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rand_done got cnt %0d v %b rdy %b exp 1000 1 0", sample_cnt, sig_valid, in_ready); end
        sig_ready = 1'b1;
        tick;
        sig_ready = 1'b0;
        checks++; if (busy !== 1'b0 || sig !== model) begin errors++; $display("FAIL rand_release got busy %b sig %h exp 0 %h", busy, sig, model); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = 16'd0; y = 15'h0;
        in_valid = 1'b0; sig_ready = 1'b0;
        test_reset;
        test_single;
        test_stall;
        test_zero;
        test_hold_stable;
        test_reset_midrun;
        test_random_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
